stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 104 ++++++++++
 tb/tb_stream_packer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// Stream packer: buffers single items in a circular FIFO and presents beats of up
// to MAX_OUTPUTS lanes, closing a beat early at the first item flagged last.
module stream_packer #(
  parameter int  BIT_WIDTH   = 32,
  parameter int  MAX_OUTPUTS = 4,
  parameter int  FIFO_DEPTH  = 256,
  parameter type DATA_TYPE   = logic [BIT_WIDTH-1:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  DATA_TYPE               in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output DATA_TYPE               out_data [0:MAX_OUTPUTS-1],
  output logic [MAX_OUTPUTS-1:0] out_keep,
  output logic                   out_last,
  input  logic                   out_ready
);

  if (MAX_OUTPUTS <= 0 || (MAX_OUTPUTS % 2) != 0) begin : g_badOutputs
    $fatal(1, "stream_packer: MAX_OUTPUTS must be positive and even");
  end
  if (MAX_OUTPUTS <= 0 || FIFO_DEPTH <= 0 || (FIFO_DEPTH % MAX_OUTPUTS) != 0) begin : g_badDepth
    $fatal(1, "stream_packer: FIFO_DEPTH must be positive and a multiple of MAX_OUTPUTS");
  end

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int N_W   = $clog2(MAX_OUTPUTS + 1);

  DATA_TYPE         r_mem     [0:FIFO_DEPTH-1];
  logic             r_lastMem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;

  logic [N_W-1:0]   w_n;
  logic             w_found;
  logic [PTR_W-1:0] w_lanePtr [0:MAX_OUTPUTS-1];
  logic             w_push;
  logic             w_pop;

  // Depth need not be a power of two, so pointer arithmetic wraps explicitly.
  function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= FIFO_DEPTH) sum = sum - FIFO_DEPTH;
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    w_n     = '0;
    w_found = 1'b0;
    for (int j = 0; j < MAX_OUTPUTS; j++) begin
      w_lanePtr[j] = wrapAdd(r_rdPtr, j);
      if (!w_found && j < int'(r_count) && r_lastMem[w_lanePtr[j]]) begin
        w_n     = N_W'(j + 1);
        w_found = 1'b1;
      end
    end
    if (!w_found && int'(r_count) >= MAX_OUTPUTS) w_n = N_W'(MAX_OUTPUTS);
  end

  always_comb begin
    out_keep = '0;
    out_last = 1'b0;
    for (int j = 0; j < MAX_OUTPUTS; j++) begin
      out_data[j] = '0;
      if (j < int'(w_n)) begin
        out_data[j] = r_mem[w_lanePtr[j]];
        out_keep[j] = 1'b1;
      end
      if (j + 1 == int'(w_n)) out_last = r_lastMem[w_lanePtr[j]];
    end
  end

  assign out_valid = (w_n != '0);
  assign in_ready  = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= wrapAdd(r_wrPtr, 1);
      if (w_pop) r_rdPtr <= wrapAdd(r_rdPtr, int'(w_n));
      r_count <= r_count + CNT_W'(w_push) - (w_pop ? CNT_W'(w_n) : '0);
    end
  end

  // Storage is left unreset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr]     <= in_data;
      r_lastMem[r_wrPtr] <= in_last;
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_stream_packer;

  localparam int BW    = 32;
  localparam int LANES = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  logic [BW-1:0]    inData;
  logic             inLast;
  logic             inReady;
  logic             outValid;
  logic [BW-1:0]    outData [0:LANES-1];
  logic [LANES-1:0] outKeep;
  logic             outLast;
  logic             outReady;

  int testCount = 0;
  int failCount = 0;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } item_t;

  item_t modelQ[$];

  stream_packer #(
    .BIT_WIDTH  (BW),
    .MAX_OUTPUTS(LANES),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_data  (inData),
    .in_last  (inLast),
    .in_ready (inReady),
    .out_valid(outValid),
    .out_data (outData),
    .out_keep (outKeep),
    .out_last (outLast),
    .out_ready(outReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Beat size straight from the grouping rule: stop at the first last, else a full beat.
  function automatic int beatSize();
    for (int k = 0; k < modelQ.size() && k < LANES; k++)
      if (modelQ[k].last) return k + 1;
    if (modelQ.size() >= LANES) return LANES;
    return 0;
  endfunction

  task automatic applyStimulus(input logic v, input logic [BW-1:0] d, input logic l,
                               input logic r, input logic doReset);
    int               n;
    bit               canPush;
    logic [127:0]     expData;
    logic [127:0]     gotData;
    logic [LANES-1:0] expKeep;
    logic             expLast;
    rst      = doReset;
    inValid  = v;
    inData   = d;
    inLast   = l;
    outReady = r;
    #1;
    n       = beatSize();
    canPush = (modelQ.size() < DEPTH);
    expData = '0;
    expKeep = '0;
    expLast = 1'b0;
    for (int j = 0; j < n; j++) begin
      expData[j*BW +: BW] = modelQ[j].data;
      expKeep[j]          = 1'b1;
    end
    if (n > 0) expLast = modelQ[n-1].last;
    gotData = '0;
    for (int j = 0; j < LANES; j++) gotData[j*BW +: BW] = outData[j];
    checkOutput("in_ready",  128'(inReady),  128'(canPush));
    checkOutput("out_valid", 128'(outValid), 128'(n > 0));
    checkOutput("out_keep",  128'(outKeep),  128'(expKeep));
    checkOutput("out_last",  128'(outLast),  128'(expLast));
    checkOutput("out_data",  gotData,        expData);
    @(posedge clk);
    if (doReset) begin
      modelQ.delete();
    end else begin
      if (r && n > 0) repeat (n) void'(modelQ.pop_front());
      if (v && canPush) modelQ.push_back('{data: d, last: l});
    end
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    inValid  = 1'b0;
    inData   = '0;
    inLast   = 1'b0;
    outReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelQ.delete();
  endtask

  initial begin
    resetDut();

    // Full group of four, then drain.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, BW'(i), 1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Short group closed by last; the trailing item waits.
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd6, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd7, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd8, 1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Fill to capacity with the consumer stalled, then drain.
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, BW'(20 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd99, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd98, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Six items through, then a beat that straddles the wrap point.
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, BW'(40 + i), (i == 5), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 10; i <= 13; i++) applyStimulus(1'b1, BW'(i), 1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Continuous push with an always-ready consumer.
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, $urandom, ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Reset with items buffered, then a single closed item.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, BW'(60 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd70, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'd71, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) == 0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
